// File: rtl/acc_reg_pkg.sv
// Shared constants and mode encodings for the shift/accumulate register and
// the multiplier controller that drives it.
package acc_reg_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_SHIFT_W = 4;
  localparam int DEF_CNT_W   = 4;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_ADD  = 2'b10,
    MODE_SHL  = 2'b11
  } mode_e;

endpackage

// File: rtl/acc_reg_if.sv
// Operation/result bundle between the multiplier controller and acc_reg.
// The ovf signal exists only when ACC_REG_OVF_EN is defined.
interface acc_reg_if
  import acc_reg_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int CNT_W   = DEF_CNT_W
);

  logic               clk_ena;
  mode_e              mode;
  logic [SHIFT_W-1:0] shift_amt;
  logic [WIDTH-1:0]   datain;
  logic [WIDTH-1:0]   reg_out;
  logic               carry;
  logic [CNT_W-1:0]   op_count;
`ifdef ACC_REG_OVF_EN
  logic               ovf;

  modport master (output clk_ena, mode, shift_amt, datain,
                  input  reg_out, carry, op_count, ovf);
  modport slave  (input  clk_ena, mode, shift_amt, datain,
                  output reg_out, carry, op_count, ovf);
`else
  modport master (output clk_ena, mode, shift_amt, datain,
                  input  reg_out, carry, op_count);
  modport slave  (input  clk_ena, mode, shift_amt, datain,
                  output reg_out, carry, op_count);
`endif

endinterface

// File: rtl/acc_reg_shl.sv
// Combinational zero-filling left shifter that also reports whether any
// nonzero bit fell off the top. Distances of WIDTH or more give zero.
module acc_reg_shl #(
  parameter int WIDTH   = 16,
  parameter int SHIFT_W = 4
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [SHIFT_W-1:0] amt,
  output logic [WIDTH-1:0]   dout,
  output logic               lost
);

  logic [2*WIDTH-1:0] wide;

  // Shift in a double-width word so the upper half holds exactly the lost bits.
  always_comb begin
    wide = '0;
    dout = '0;
    lost = 1'b0;
    if (32'(amt) >= WIDTH) begin
      lost = |din;
    end else begin
      wide = {{WIDTH{1'b0}}, din} << amt;
      dout = wide[WIDTH-1:0];
      lost = |wide[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/acc_reg.sv
// Parametrised shift/accumulate register for the sequential multiplier.
// Define ACC_REG_OVF_EN to add the sticky overflow flag.
module acc_reg
  import acc_reg_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic      clk,
  input  logic      sclr,
  acc_reg_if.slave  bus
);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] addend;
  logic             add_lost_unused;
  logic [WIDTH-1:0] shl_val;
  logic             shl_lost;
  logic [WIDTH:0]   sum;
`ifdef ACC_REG_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Addend bits pushed past the top are simply dropped and never reach carry.
  acc_reg_shl #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) u_add_shl (
    .din  (bus.datain),
    .amt  (bus.shift_amt),
    .dout (addend),
    .lost (add_lost_unused)
  );

  acc_reg_shl #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) u_reg_shl (
    .din  (reg_q),
    .amt  (bus.shift_amt),
    .dout (shl_val),
    .lost (shl_lost)
  );

  assign sum = {1'b0, reg_q} + {1'b0, addend};

  always_comb begin
    reg_d   = reg_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef ACC_REG_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (bus.clk_ena) begin
      case (bus.mode)
        MODE_LOAD: begin
          reg_d   = bus.datain;
          carry_d = 1'b0;
          cnt_d   = '0;
`ifdef ACC_REG_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
        MODE_ADD: begin
          {carry_d, reg_d} = sum;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`ifdef ACC_REG_OVF_EN
          ovf_d = ovf_q | sum[WIDTH];
`endif
        end
        MODE_SHL: begin
          reg_d   = shl_val;
          carry_d = shl_lost;
`ifdef ACC_REG_OVF_EN
          ovf_d   = ovf_q | shl_lost;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      reg_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef ACC_REG_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      reg_q   <= reg_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef ACC_REG_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.reg_out  = reg_q;
  assign bus.carry    = carry_q;
  assign bus.op_count = cnt_q;
`ifdef ACC_REG_OVF_EN
  assign bus.ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_acc_reg.sv
// Bench for acc_reg at WIDTH=16, SHIFT_W=4, CNT_W=4: fixed vector table,
// then model-driven saturation/abort and random sequences via a scoreboard.
module tb_acc_reg;
  import acc_reg_pkg::*;

  typedef struct {
    logic [15:0] reg_v;
    logic        carry;
    logic [3:0]  cnt;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        sclr;
    logic        ena;
    mode_e       mode;
    logic [3:0]  amt;
    logic [15:0] din;
    exp_t        exp;
  } vec_t;

  logic clk;
  logic sclr;
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t sb[$];
  vec_t vecs[$];

  logic [15:0] m_reg;
  logic        m_carry;
  logic [3:0]  m_cnt;
  logic        m_ovf;

  acc_reg_if #(.WIDTH(16), .SHIFT_W(4), .CNT_W(4)) bus ();

  acc_reg #(.WIDTH(16), .SHIFT_W(4), .CNT_W(4)) dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL %s: scoreboard empty, got reg=%h", name, bus.reg_out);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (bus.reg_out !== e.reg_v) begin
      n_fail++;
      $display("[TB] FAIL %s reg_out: got %h want %h", name, bus.reg_out, e.reg_v);
    end
    n_checks++;
    if (bus.carry !== e.carry) begin
      n_fail++;
      $display("[TB] FAIL %s carry: got %b want %b", name, bus.carry, e.carry);
    end
    n_checks++;
    if (bus.op_count !== e.cnt) begin
      n_fail++;
      $display("[TB] FAIL %s op_count: got %0d want %0d", name, bus.op_count, e.cnt);
    end
`ifdef ACC_REG_OVF_EN
    n_checks++;
    if (bus.ovf !== e.ovf) begin
      n_fail++;
      $display("[TB] FAIL %s ovf: got %b want %b", name, bus.ovf, e.ovf);
    end
`endif
  endtask

  task automatic applyStimulus(input logic s, input logic e, input mode_e m,
                               input logic [3:0] a, input logic [15:0] d,
                               input exp_t ex, input string name);
    sclr          = s;
    bus.clk_ena   = e;
    bus.mode      = m;
    bus.shift_amt = a;
    bus.datain    = d;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  // Reference model works on 64-bit words so truncation and lost bits fall out naturally.
  task automatic applyModel(input logic s, input logic e, input mode_e m,
                            input logic [3:0] a, input logic [15:0] d,
                            input string name);
    logic [63:0] wide;
    exp_t ex;
    if (s) begin
      m_reg = '0; m_carry = 1'b0; m_cnt = '0; m_ovf = 1'b0;
    end else if (e) begin
      case (m)
        MODE_LOAD: begin
          m_reg = d; m_carry = 1'b0; m_cnt = '0; m_ovf = 1'b0;
        end
        MODE_ADD: begin
          wide = 64'(m_reg) + ((64'(d) << a) & 64'h0000_0000_0000_FFFF);
          m_reg = wide[15:0];
          m_carry = wide[16];
          if (m_cnt < 4'd15) m_cnt = m_cnt + 4'd1;
          m_ovf = m_ovf | m_carry;
        end
        MODE_SHL: begin
          wide = 64'(m_reg) << a;
          m_reg = wide[15:0];
          m_carry = (wide[63:16] != 48'd0);
          m_ovf = m_ovf | m_carry;
        end
        default: ;
      endcase
    end
    ex.reg_v = m_reg; ex.carry = m_carry; ex.cnt = m_cnt; ex.ovf = m_ovf;
    applyStimulus(s, e, m, a, d, ex, name);
  endtask

  initial begin
    sclr          = 1'b0;
    bus.clk_ena   = 1'b0;
    bus.mode      = MODE_HOLD;
    bus.shift_amt = '0;
    bus.datain    = '0;
    m_reg = '0; m_carry = 1'b0; m_cnt = '0; m_ovf = 1'b0;

    //                sclr  ena   mode       amt    din        reg       c     cnt    ovf
    vecs.push_back('{1'b1, 1'b0, MODE_HOLD, 4'd0,  16'h0000, '{16'h0000, 1'b0, 4'd0, 1'b0}});
    vecs.push_back('{1'b0, 1'b1, MODE_LOAD, 4'd0,  16'hCCF3, '{16'hCCF3, 1'b0, 4'd0, 1'b0}});
    vecs.push_back('{1'b0, 1'b0, MODE_LOAD, 4'd0,  16'h0F0F, '{16'hCCF3, 1'b0, 4'd0, 1'b0}});
    vecs.push_back('{1'b0, 1'b0, MODE_LOAD, 4'd0,  16'h0F0F, '{16'hCCF3, 1'b0, 4'd0, 1'b0}});
    vecs.push_back('{1'b0, 1'b0, MODE_LOAD, 4'd0,  16'h0F0F, '{16'hCCF3, 1'b0, 4'd0, 1'b0}});
    vecs.push_back('{1'b0, 1'b1, MODE_LOAD, 4'd0,  16'h0000, '{16'h0000, 1'b0, 4'd0, 1'b0}});
    vecs.push_back('{1'b0, 1'b1, MODE_ADD,  4'd0,  16'h00B5, '{16'h00B5, 1'b0, 4'd1, 1'b0}});
    vecs.push_back('{1'b0, 1'b1, MODE_ADD,  4'd2,  16'h00B5, '{16'h0389, 1'b0, 4'd2, 1'b0}});
    vecs.push_back('{1'b0, 1'b1, MODE_ADD,  4'd3,  16'h00B5, '{16'h0931, 1'b0, 4'd3, 1'b0}});
    vecs.push_back('{1'b0, 1'b1, MODE_LOAD, 4'd0,  16'hFFFF, '{16'hFFFF, 1'b0, 4'd0, 1'b0}});
    vecs.push_back('{1'b0, 1'b1, MODE_ADD,  4'd0,  16'h0001, '{16'h0000, 1'b1, 4'd1, 1'b1}});
    vecs.push_back('{1'b0, 1'b1, MODE_ADD,  4'd0,  16'h0001, '{16'h0001, 1'b0, 4'd2, 1'b1}});
    vecs.push_back('{1'b0, 1'b1, MODE_HOLD, 4'd5,  16'h1234, '{16'h0001, 1'b0, 4'd2, 1'b1}});
    vecs.push_back('{1'b0, 1'b1, MODE_LOAD, 4'd0,  16'h8001, '{16'h8001, 1'b0, 4'd0, 1'b0}});
    vecs.push_back('{1'b0, 1'b1, MODE_SHL,  4'd1,  16'h0000, '{16'h0002, 1'b1, 4'd0, 1'b1}});
    vecs.push_back('{1'b0, 1'b1, MODE_LOAD, 4'd0,  16'h0003, '{16'h0003, 1'b0, 4'd0, 1'b0}});
    vecs.push_back('{1'b0, 1'b1, MODE_SHL,  4'd15, 16'h0000, '{16'h8000, 1'b1, 4'd0, 1'b1}});
    vecs.push_back('{1'b0, 1'b1, MODE_SHL,  4'd0,  16'h0000, '{16'h8000, 1'b0, 4'd0, 1'b1}});
    vecs.push_back('{1'b0, 1'b1, MODE_ADD,  4'd8,  16'hFFFF, '{16'h7F00, 1'b1, 4'd1, 1'b1}});
    vecs.push_back('{1'b0, 1'b1, MODE_LOAD, 4'd0,  16'h00F0, '{16'h00F0, 1'b0, 4'd0, 1'b0}});
    vecs.push_back('{1'b0, 1'b1, MODE_ADD,  4'd4,  16'hF00F, '{16'h01E0, 1'b0, 4'd1, 1'b0}});
    vecs.push_back('{1'b1, 1'b1, MODE_ADD,  4'd0,  16'h0001, '{16'h0000, 1'b0, 4'd0, 1'b0}});

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].sclr, vecs[i].ena, vecs[i].mode, vecs[i].amt,
                    vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Dirty the state, then clear with the enable low.
    applyModel(1'b0, 1'b1, MODE_LOAD, 4'd0, 16'($urandom_range(1, 16'hFFFF)), "rnd_load");
    applyModel(1'b0, 1'b1, MODE_ADD, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 16'hFFFF)), "rnd_add");
    applyModel(1'b1, 1'b0, MODE_SHL, 4'd3, 16'h5555, "clear_no_ena");

    // Seventeen adds saturate the counter; sclr alongside an ADD then wins.
    applyModel(1'b0, 1'b1, MODE_LOAD, 4'd0, 16'h0000, "sat_load");
    for (int i = 0; i < 17; i++) begin
      applyModel(1'b0, 1'b1, MODE_ADD, 4'($urandom_range(0, 15)),
                 16'($urandom_range(0, 16'hFFFF)), $sformatf("sat_add%0d", i));
    end
    n_checks++;
    if (bus.op_count !== 4'd15) begin
      n_fail++;
      $display("[TB] FAIL saturation: got %0d want 15", bus.op_count);
    end
    applyModel(1'b1, 1'b1, MODE_ADD, 4'd1, 16'h0007, "abort");

    for (int i = 0; i < 60; i++) begin
      applyModel(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
                 mode_e'(2'($urandom_range(0, 3))), 4'($urandom_range(0, 15)),
                 16'($urandom_range(0, 16'hFFFF)), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_reg.md
# acc_reg

Parametrised shift/accumulate register, the successor to the fixed 16-bit enable/clear register in the sequential multiplier datapath. It adds width parametrisation, a mode select (hold, load, shifted add, shift left), a registered carry, an add-operation counter and an optional sticky overflow flag. It is the product/partial-sum register the multiplier controller drives one operation per enabled clock edge.

## Interface
- WIDTH, 16: data and register width in bits (≥2)
- SHIFT_W, 4: width of shift_amt
- CNT_W, 4: width of op_count
- clk  in  1  rising-edge clock
- sclr  in  1  synchronous clear, active-high; one clock, synchronous active-high reset
- clk_ena  in  1  operation enable; sampled at the rising edge
- mode  in  2  00 HOLD, 01 LOAD, 10 ADD, 11 SHL
- shift_amt  in  SHIFT_W  left-shift distance for ADD and SHL
- datain  in  WIDTH  load value or addend
- reg_out  out  WIDTH  register contents
- carry  out  1  carry/shift-out flag of the last LOAD/ADD/SHL
- op_count  out  CNT_W  ADDs since the last LOAD or clear; saturating
- ovf  out  1  sticky overflow; present only with ACC_REG_OVF_EN

## Operation
- Reset: all state is cleared on the edge where sclr=1, regardless of clk_ena and mode. Then reg_out=0, carry=0, op_count=0, ovf=0.
- When sclr=0 and clk_ena=0, all state holds.
- When sclr=0 and clk_ena=1, the action depends on mode:
  - HOLD: no change to any state.
  - LOAD: reg_out←datain, carry←0, op_count←0, ovf←0.
  - ADD: {carry, reg_out}←reg_out + (datain << shift_amt).
    - The shifted addend is truncated to WIDTH bits before the add.
    - Addend bits shifted beyond WIDTH are discarded and do not affect carry.
    - op_count increments and saturates at 2^CNT_W−1.
  - SHL: reg_out←reg_out << shift_amt, zero-filled.
    - carry←1 if any nonzero bit was shifted out, else 0.
    - op_count is unchanged.
- Shift rules:
  - shift_amt=0 means no shift.
  - shift_amt ≥ WIDTH gives a shifted value of 0. For SHL, carry is then 1 if reg_out was nonzero.
- ovf is set on any ADD or SHL edge that produces carry=1. It stays set until sclr or LOAD.
- Arithmetic is unsigned and modulo 2^WIDTH.

## Timing
- Single-cycle latency: every result is visible on the outputs immediately after the capturing rising edge.
- All outputs are registered; there is no combinational input-to-output path.
- No handshake: each enabled edge performs exactly one operation. Back-to-back operations are allowed every cycle.
- Simultaneous events: sclr dominates clk_ena and mode. An ADD presented in the same cycle as sclr=1 is lost and is not counted.
- Asserting sclr in the middle of a shift-add sequence aborts the sequence. The next edge shows all-zero outputs.

## Configuration
- ACC_REG_OVF_EN defined: the ovf port and its sticky flop exist, behaving as described above.
- ACC_REG_OVF_EN undefined: the ovf port and its logic are removed. All other behaviour is bit-identical.

## Structure
- Package acc_reg_pkg holds:
  - the 2-bit mode encodings (MODE_HOLD, MODE_LOAD, MODE_ADD, MODE_SHL) as localparams or an enum typedef;
  - default WIDTH, SHIFT_W and CNT_W constants shared with the multiplier controller.
- One sub-module: acc_reg_shl, a combinational left shifter parametrised by WIDTH/SHIFT_W. It outputs the shifted value and a lost-bits-nonzero flag, and is instantiated twice (ADD addend path and SHL path).

## Test plan
All scenarios use WIDTH=16, SHIFT_W=4, CNT_W=4.
- Clear: sclr=1, clk_ena=0 from random state → after one edge, reg_out=0x0000, carry=0, op_count=0, ovf=0.
- Enable gating: LOAD 0xCCF3, clk_ena=1 → reg_out=0xCCF3. Then LOAD 0x0F0F with clk_ena=0 for 3 edges → reg_out stays 0xCCF3.
- Shift-add multiply 0xB5×0x0D: LOAD 0, then ADD datain=0x00B5 at shift_amt 0, 2, 3 → reg_out=0x0931, op_count=3, carry=0, ovf=0.
- Overflow: LOAD 0xFFFF, ADD datain=0x0001 shift 0 → reg_out=0x0000, carry=1, ovf=1. Next ADD 0x0001 → reg_out=0x0001, carry=0, ovf=1. A following LOAD clears ovf.
- Shift-left: LOAD 0x8001, SHL 1 → 0x0002, carry=1. LOAD 0x0003, SHL 15 → 0x8000, carry=1. SHL with shift_amt=0 → unchanged, carry=0.
- Saturation and abort: 17 consecutive ADDs → op_count=15. Then sclr=1 together with mode=ADD → next edge reg_out=0, op_count=0.
